pipe_stage_hold_reg: RTL and testbench

Parametrised pipeline-stage register for the in-order core. It carries a control payload and a valid/write-enable pair across a stage boundary with stall (hold) and flush (bubble) control. It also provides per-channel hold buffering for read data from synchronous-read memories (dcache, CSR file, …), so that data stays stable for as long as the stage is stalled. A saturating stall-cycle counter is included for performance debug. It generalises the fixed MEM/WB register to arbitrary payload width, multiple sync-read channels, flush, and validity tracking.

---
 rtl/pipe_stage_hold_reg.sv | 137 +++++++++++++
 tb/tb_pipe_stage_hold_reg.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_hold_reg.sv
// pipe_stage_hold_reg
// Pipeline-stage register with stall (hold) and flush (bubble) control.
// Carries a valid / write-enable pair and a control payload across a stage
// boundary. Each sync-read memory channel can be hold-buffered, so its data
// stays stable for as long as the stage is stalled. Also keeps a saturating
// count of stalled valid cycles for performance debug.
//
// Priority at each edge: reset > flush > stall > advance.
// Stall never reaches an output combinationally. Outputs that depend on stall
// are driven only from registers: r_hold_sel, the payload and the counter.

module pipe_stage_hold_reg #(
    parameter int                 CTRL_W    = 174,
    parameter int                 DATA_W    = 32,
    parameter int                 NCH       = 1,
    parameter logic [NCH-1:0]     HOLD_MASK = {NCH{1'b1}},
    parameter int                 CNT_W     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   valid_in,
    input  logic                   we_in,
    input  logic [CTRL_W-1:0]      ctrl_in,
    input  logic [NCH*DATA_W-1:0]  sdata_in,
    input  logic                   cnt_clr,
    output logic                   valid_out,
    output logic                   we_out,
    output logic [CTRL_W-1:0]      ctrl_out,
    output logic [NCH*DATA_W-1:0]  sdata_out,
    output logic [CNT_W-1:0]       stall_cnt
);

    // ------------------------------------------------------------------
    // Stage state
    // ------------------------------------------------------------------
    logic              r_valid;
    logic              r_we;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_hold_sel;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_advance;
    logic              w_cnt_event;
    logic              w_cnt_sat;

    assign w_advance   = !stall;
    assign w_cnt_event = stall && r_valid;
    assign w_cnt_sat   = (r_stall_cnt == {CNT_W{1'b1}});

    // Valid / write-enable: flush kills the entry even while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
        end else if (w_advance) begin
            r_valid <= valid_in;
            r_we    <= we_in & valid_in;
        end
    end

    // Payload: loads when not stalled, independent of flush. Its value is
    // irrelevant while the entry is a bubble, so flush does not touch it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl <= '0;
        end else if (w_advance) begin
            r_ctrl <= ctrl_in;
        end
    end

    // Registered copy of stall. It selects the hold buffers one cycle into
    // a stall, which keeps stall off every combinational output path.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_sel <= 1'b0;
        end else begin
            r_hold_sel <= stall;
        end
    end

    // Saturating stalled-valid-cycle counter. The clear wins over the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (w_cnt_event && !w_cnt_sat) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-channel sync-read hold
    // ------------------------------------------------------------------
    // Each hold buffer recirculates the visible output. The value seen in
    // the first stall cycle is captured at that edge and then re-captured
    // for every later stalled edge. It also covers the first cycle after
    // release, because r_hold_sel still reads 1 during that cycle.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [DATA_W-1:0] w_ch_in;
        logic [DATA_W-1:0] w_ch_out;

        assign w_ch_in = sdata_in[gi*DATA_W +: DATA_W];
        assign sdata_out[gi*DATA_W +: DATA_W] = w_ch_out;

        if (HOLD_MASK[gi]) begin : g_hold
            logic [DATA_W-1:0] r_hold_buf;

            // Capture whatever the channel is presenting at every edge.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_hold_buf <= '0;
                end else begin
                    r_hold_buf <= w_ch_out;
                end
            end

            assign w_ch_out = r_hold_sel ? r_hold_buf : w_ch_in;
        end else begin : g_pass
            assign w_ch_out = w_ch_in;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign valid_out = r_valid;
    assign we_out    = r_we;
    assign ctrl_out  = r_ctrl;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_hold_reg.sv
// tb_pipe_stage_hold_reg
// Directed stimulus with hand-computed expectations. The stimulus pushes each
// expected value into a queue, tagged with the cycle in which it must be seen.
// A separate monitor samples the DUT every cycle and pops and compares the
// entries that are due.

module tb_pipe_stage_hold_reg;

    localparam int CTRL_W = 16;
    localparam int DATA_W = 8;
    localparam int NCH    = 2;
    localparam int CNT_W  = 3;

    localparam int K_V  = 0;
    localparam int K_W  = 1;
    localparam int K_C  = 2;
    localparam int K_S0 = 3;
    localparam int K_S1 = 4;
    localparam int K_N  = 5;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset, stall, flush, valid_in, we_in, cnt_clr;
    logic [CTRL_W-1:0]     ctrl_in;
    logic [NCH*DATA_W-1:0] sdata_in;
    logic                  valid_out, we_out;
    logic [CTRL_W-1:0]     ctrl_out;
    logic [NCH*DATA_W-1:0] sdata_out;
    logic [CNT_W-1:0]      stall_cnt;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   scyc  = 0;
    int   mcyc  = 0;

    pipe_stage_hold_reg #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NCH(NCH),
        .HOLD_MASK(2'b01), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_in(valid_in), .we_in(we_in), .ctrl_in(ctrl_in),
        .sdata_in(sdata_in), .cnt_clr(cnt_clr),
        .valid_out(valid_out), .we_out(we_out), .ctrl_out(ctrl_out),
        .sdata_out(sdata_out), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        scyc++;
    endtask

    task automatic drv(input logic rst, input logic st, input logic fl,
                       input logic vi, input logic wi, input logic [15:0] c,
                       input logic cc, input logic [7:0] s0, input logic [7:0] s1);
        reset    = rst;
        stall    = st;
        flush    = fl;
        valid_in = vi;
        we_in    = wi;
        ctrl_in  = c;
        cnt_clr  = cc;
        sdata_in = {s1, s0};
    endtask

    task automatic exp_push(input int kind, input logic [31:0] val, input string name);
        exp_t e;
        e.cyc  = scyc;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        q.push_back(e);
    endtask

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            K_V:     return 32'(valid_out);
            K_W:     return 32'(we_out);
            K_C:     return 32'(ctrl_out);
            K_S0:    return 32'(sdata_out[7:0]);
            K_S1:    return 32'(sdata_out[15:8]);
            default: return 32'(stall_cnt);
        endcase
    endfunction

    // Monitor: samples 2 time units after each falling edge, after the new
    // inputs have been applied.
    initial begin
        exp_t e;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            #2;
            mcyc++;
            while (q.size() > 0 && q[0].cyc <= mcyc) begin
                e = q.pop_front();
                n_cmp++;
                if (e.cyc < mcyc) begin
                    n_bad++;
                    $display("FAIL %s cyc %0d: not sampled in time (now cyc %0d), expected %h",
                             e.name, e.cyc, mcyc, e.val);
                end else begin
                    a = actual(e.kind);
                    if (a !== e.val) begin
                        n_bad++;
                        $display("FAIL %s cyc %0d: got %h expected %h", e.name, e.cyc, a, e.val);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drv(1, 0, 0, 0, 0, 16'h0000, 0, 8'h00, 8'h00);
        tick();                                                   // c1
        drv(1, 0, 0, 0, 0, 16'h0000, 0, 8'h00, 8'h00);
        tick();                                                   // c2
        drv(0, 0, 0, 1, 1, 16'h00A5, 0, 8'h5A, 8'h3C);
        exp_push(K_V, 0, "rst_valid");
        exp_push(K_W, 0, "rst_we");
        exp_push(K_C, 0, "rst_ctrl");
        exp_push(K_N, 0, "rst_cnt");
        exp_push(K_S0, 32'h5A, "rst_pass_s0");
        exp_push(K_S1, 32'h3C, "rst_pass_s1");
        tick();                                                   // c3
        drv(0, 1, 0, 1, 1, 16'h1234, 0, 8'h11, 8'h61);
        exp_push(K_V, 1, "adv_valid");
        exp_push(K_W, 1, "adv_we");
        exp_push(K_C, 32'h00A5, "adv_ctrl");
        exp_push(K_S0, 32'h11, "stall1_s0");
        exp_push(K_S1, 32'h61, "stall1_s1");
        exp_push(K_N, 0, "stall1_cnt");
        tick();                                                   // c4
        drv(0, 1, 0, 1, 1, 16'h1234, 0, 8'h22, 8'h62);
        exp_push(K_S0, 32'h11, "stall2_s0");
        exp_push(K_S1, 32'h62, "stall2_s1_pass");
        exp_push(K_C, 32'h00A5, "stall2_ctrl");
        exp_push(K_N, 1, "stall2_cnt");
        tick();                                                   // c5
        drv(0, 1, 0, 1, 1, 16'h1234, 0, 8'h33, 8'h63);
        exp_push(K_S0, 32'h11, "stall3_s0");
        exp_push(K_S1, 32'h63, "stall3_s1_pass");
        exp_push(K_C, 32'h00A5, "stall3_ctrl");
        exp_push(K_N, 2, "stall3_cnt");
        tick();                                                   // c6
        drv(0, 0, 0, 1, 0, 16'h1234, 0, 8'h44, 8'h64);
        exp_push(K_S0, 32'h11, "release1_s0");
        exp_push(K_S1, 32'h64, "release1_s1");
        exp_push(K_C, 32'h00A5, "release1_ctrl");
        exp_push(K_N, 3, "release1_cnt");
        tick();                                                   // c7
        drv(0, 0, 1, 1, 1, 16'h0F0F, 0, 8'h44, 8'h65);
        exp_push(K_S0, 32'h44, "release2_s0");
        exp_push(K_C, 32'h1234, "adv2_ctrl");
        exp_push(K_W, 0, "adv2_we");
        exp_push(K_V, 1, "adv2_valid");
        exp_push(K_N, 3, "nostall_cnt");
        tick();                                                   // c8
        drv(0, 0, 0, 1, 1, 16'h00BB, 0, 8'h45, 8'h66);
        exp_push(K_V, 0, "flush_adv_valid");
        exp_push(K_W, 0, "flush_adv_we");
        tick();                                                   // c9
        drv(0, 1, 1, 1, 1, 16'hCCCC, 0, 8'h46, 8'h67);
        exp_push(K_V, 1, "pre_flush_valid");
        exp_push(K_C, 32'h00BB, "pre_flush_ctrl");
        tick();                                                   // c10
        drv(0, 0, 0, 0, 0, 16'h0000, 0, 8'h47, 8'h68);
        exp_push(K_V, 0, "flush_stall_valid");
        exp_push(K_W, 0, "flush_stall_we");
        exp_push(K_C, 32'h00BB, "flush_stall_ctrl");
        exp_push(K_N, 4, "flush_stall_cnt");
        tick();                                                   // c11
        drv(0, 0, 0, 1, 1, 16'h0077, 0, 8'h48, 8'h69);
        exp_push(K_V, 0, "bubble_valid");
        for (int i = 0; i < 10; i++) begin                        // c12..c21
            tick();
            drv(0, 1, 0, 1, 1, 16'h0077, 0, 8'h50, 8'h70);
            if (i == 1) exp_push(K_N, 5, "sat_cnt_5");
            if (i == 3) exp_push(K_N, 7, "sat_cnt_7");
        end
        tick();                                                   // c22
        drv(0, 1, 0, 1, 1, 16'h0077, 1, 8'h50, 8'h70);
        exp_push(K_N, 7, "sat_no_wrap");
        tick();                                                   // c23
        drv(0, 1, 0, 1, 1, 16'h0077, 0, 8'h50, 8'h70);
        exp_push(K_N, 0, "clr_over_inc");
        tick();                                                   // c24
        drv(0, 1, 0, 1, 1, 16'h0077, 0, 8'h50, 8'h70);
        exp_push(K_N, 1, "count_restart");
        tick();                                                   // c25
        drv(0, 0, 0, 1, 1, 16'h0077, 0, 8'h50, 8'h70);
        exp_push(K_N, 2, "count_restart2");
        tick();                                                   // c26
        drv(0, 1, 0, 1, 1, 16'h0077, 0, 8'h81, 8'h91);
        exp_push(K_S0, 32'h81, "rs_first_s0");
        tick();                                                   // c27
        drv(1, 1, 0, 1, 1, 16'h0077, 0, 8'h82, 8'h92);
        exp_push(K_S0, 32'h81, "rs_second_s0");
        exp_push(K_N, 3, "rs_second_cnt");
        tick();                                                   // c28
        drv(0, 1, 0, 1, 1, 16'h0077, 0, 8'h83, 8'h93);
        exp_push(K_V, 0, "rs_valid");
        exp_push(K_W, 0, "rs_we");
        exp_push(K_C, 0, "rs_ctrl");
        exp_push(K_N, 0, "rs_cnt");
        exp_push(K_S0, 32'h83, "rs_pass_s0");
        exp_push(K_S1, 32'h93, "rs_pass_s1");
        tick();                                                   // c29
        drv(0, 1, 0, 1, 1, 16'h0077, 0, 8'h84, 8'h94);
        exp_push(K_S0, 32'h83, "rs_hold_resume_s0");
        exp_push(K_N, 0, "rs_invalid_nocount");
        tick();                                                   // c30
        drv(0, 0, 0, 0, 0, 16'h0000, 0, 8'h00, 8'h00);
        tick();
        tick();
        #5;
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s cyc %0d: never sampled, expected %h", e.name, e.cyc, e.val);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
